// File: rtl/uart_sram_tx_interface_pkg.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface_pkg
// Shared definitions for the SRAM-to-UART transmit path: FSM state encoding,
// SRAM read latency, UART frame length and the running-checksum helper.
// -----------------------------------------------------------------------------
package uart_sram_tx_interface_pkg;

  localparam int TX_SRAM_READ_LATENCY = 2;
  localparam int UART_FRAME_BITS      = 10;
  localparam int TX_ADDR_W            = 18;
  localparam int TX_DATA_W            = 16;

  typedef enum logic [2:0] {
    S_TX_IDLE    = 3'd0,
    S_TX_ISSUE   = 3'd1,
    S_TX_WAIT1   = 3'd2,
    S_TX_WAIT2   = 3'd3,
    S_TX_SEND_HI = 3'd4,
    S_TX_SEND_LO = 3'd5,
    S_TX_CHK     = 3'd6,
    S_TX_DONE    = 3'd7
  } tx_state_type;

  // Running byte sum, modulo 256.
  function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_if.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface_if
// Bundles the host handshake, the SRAM read port and the UART line of the
// SRAM-to-UART transmitter.
//   start          host -> tx   one-cycle start pulse
//   start_address  host -> tx   first SRAM word address
//   word_count     host -> tx   number of 16-bit words to send
//   sram_address   tx -> sram   read address
//   sram_read_data sram -> tx   read data, valid 2 cycles after the address
//   sram_we_n      tx -> sram   write enable (active low, always 1)
//   uart_tx        tx -> host   serial line, idles high
//   busy / done    tx -> host   status
// Modports: master = host/SRAM side, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_sram_tx_interface_if;

  logic        start;
  logic [17:0] start_address;
  logic [17:0] word_count;
  logic [17:0] sram_address;
  logic [15:0] sram_read_data;
  logic        sram_we_n;
  logic        uart_tx;
  logic        busy;
  logic        done;

  modport master (
    output start, start_address, word_count, sram_read_data,
    input  sram_address, sram_we_n, uart_tx, busy, done
  );

  modport slave (
    input  start, start_address, word_count, sram_read_data,
    output sram_address, sram_we_n, uart_tx, busy, done
  );

endinterface

// File: rtl/uart_sram_tx_interface_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serializer. Each bit lasts BAUD_DIVISOR clocks.
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   load_i   start a new frame with byte_i (start bit appears next cycle)
//   byte_i   byte to send, LSB first
//   tx_o     registered serial line, idles high
//   ready_o  high on the last clock of the stop bit, so a load in that
//            cycle continues with no idle gap
// -----------------------------------------------------------------------------
module uart_tx_byte
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int BAUD_DIVISOR = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       ready_o
);

  localparam int              BW        = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIVISOR - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic          active_q, active_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic [8:0]    shift_q, shift_d;   // remaining data bits plus stop bit
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;       // 0 = start bit ... 9 = stop bit

  // Next-state logic for the bit/baud counters and the line.
  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    if (load_i) begin
      active_d = 1'b1;
      tx_d     = 1'b0;
      shift_d  = {1'b1, byte_i};
      baud_d   = '0;
      bit_d    = 4'd0;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      tx_d = 1'b1;
    end
    // Registered ready lands on the final clock of the stop bit.
    ready_d = active_d && (baud_d == BAUD_LAST) && (bit_d == BIT_LAST);
  end

  // Serializer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      shift_q  <= 9'h1FF;
      baud_q   <= '0;
      bit_q    <= 4'd0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
    end
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface
// Reads word_count 16-bit words from SRAM starting at start_address and sends
// each as two 8N1 frames, high byte first. The next word is prefetched while
// the current low byte is on the line, so frames are back-to-back.
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    uart_sram_tx_interface_if.slave (handshake, SRAM port, UART line)
// Optional build macro TX_CHECKSUM_EN: append one frame holding the mod-256
// sum of all bytes sent (a single 0x00 frame when word_count is zero).
// -----------------------------------------------------------------------------
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int BAUD_DIVISOR = 434
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  uart_sram_tx_interface_if.slave  bus
);

`ifdef TX_CHECKSUM_EN
  localparam tx_state_type S_AFTER_LAST = S_TX_CHK;
`else
  localparam tx_state_type S_AFTER_LAST = S_TX_DONE;
`endif

  tx_state_type state_q, state_d;

  logic [17:0] addr_q, addr_d;
  logic [17:0] left_q, left_d;       // words whose low byte is not yet loaded
  logic [15:0] word_q, word_d;
  logic [TX_SRAM_READ_LATENCY:0] rd_pipe_q, rd_pipe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef TX_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic        load_s;
  logic [7:0]  load_byte_s;
  logic        accept_s;
  logic        capture_s;
  logic        issue_s;
  logic        dec_s;
  logic        tx_s;
  logic        ready_s;

  uart_tx_byte #(
    .BAUD_DIVISOR (BAUD_DIVISOR)
  ) u_tx_byte (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_s),
    .byte_i  (load_byte_s),
    .tx_o    (tx_s),
    .ready_o (ready_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TX_IDLE: begin
        if (bus.start) begin
          if (bus.word_count == 18'd0) begin
            state_d = S_AFTER_LAST;
          end else begin
            state_d = S_TX_ISSUE;
          end
        end else begin
          state_d = S_TX_IDLE;
        end
      end
      S_TX_ISSUE: state_d = S_TX_WAIT1;
      S_TX_WAIT1: state_d = S_TX_WAIT2;
      S_TX_WAIT2: state_d = S_TX_SEND_HI;
      S_TX_SEND_HI: begin
        if (ready_s) begin
          state_d = S_TX_SEND_LO;
        end else begin
          state_d = S_TX_SEND_HI;
        end
      end
      S_TX_SEND_LO: begin
        if (ready_s) begin
          if (left_q != 18'd0) begin
            state_d = S_TX_SEND_HI;
          end else begin
            state_d = S_AFTER_LAST;
          end
        end else begin
          state_d = S_TX_SEND_LO;
        end
      end
      S_TX_CHK: begin
        if (ready_s) begin
          state_d = S_TX_DONE;
        end else begin
          state_d = S_TX_CHK;
        end
      end
      S_TX_DONE: state_d = S_TX_IDLE;
      default:   state_d = S_TX_IDLE;
    endcase
  end

  // FSM output strobes: serializer loads, SRAM reads, counter updates.
  always_comb begin
    load_s      = 1'b0;
    load_byte_s = 8'h00;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    issue_s     = 1'b0;
    dec_s       = 1'b0;
    case (state_q)
      S_TX_IDLE: begin
        accept_s = bus.start;
`ifdef TX_CHECKSUM_EN
        // An empty dump still emits the (zero) checksum frame.
        if (bus.start && (bus.word_count == 18'd0)) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
`endif
      end
      S_TX_WAIT2: begin
        // First word goes straight from the SRAM bus into the serializer.
        capture_s   = 1'b1;
        load_s      = 1'b1;
        load_byte_s = bus.sram_read_data[15:8];
      end
      S_TX_SEND_HI: begin
        if (ready_s) begin
          load_s      = 1'b1;
          load_byte_s = word_q[7:0];
          dec_s       = 1'b1;
          // Low byte is now held by the serializer, so word_q is free for
          // the prefetch of the next word.
          issue_s     = (left_q != 18'd1);
        end else begin
          load_s = 1'b0;
        end
      end
      S_TX_SEND_LO: begin
        if (ready_s && (left_q != 18'd0)) begin
          load_s      = 1'b1;
          load_byte_s = word_q[15:8];
`ifdef TX_CHECKSUM_EN
        end else if (ready_s) begin
          load_s      = 1'b1;
          load_byte_s = sum_q;
`endif
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: address, word counter, word register, read pipe.
  always_comb begin
    addr_d    = addr_q;
    left_d    = left_q;
    word_d    = word_q;
    rd_pipe_d = {rd_pipe_q[TX_SRAM_READ_LATENCY-1:0], issue_s};
    if (accept_s) begin
      addr_d = bus.start_address;
      left_d = bus.word_count;
    end else if (issue_s) begin
      addr_d = addr_q + 18'd1;   // wraps 3FFFF -> 0
    end else begin
      addr_d = addr_q;
    end
    if (dec_s) begin
      left_d = left_q - 18'd1;
    end else begin
      left_d = left_d;
    end
    // rd_pipe_q MSB marks the cycle the prefetched data is valid.
    if (capture_s || rd_pipe_q[TX_SRAM_READ_LATENCY]) begin
      word_d = bus.sram_read_data;
    end else begin
      word_d = word_q;
    end
    busy_d = (state_d != S_TX_IDLE);
    done_d = (state_d == S_TX_DONE);
  end

`ifdef TX_CHECKSUM_EN
  // Checksum accumulates every data byte handed to the serializer.
  always_comb begin
    sum_d = sum_q;
    if (accept_s) begin
      sum_d = 8'h00;
    end else if (load_s && ((state_q == S_TX_WAIT2) || (state_q == S_TX_SEND_HI) ||
                            ((state_q == S_TX_SEND_LO) && (left_q != 18'd0)))) begin
      sum_d = checksum_add(sum_q, load_byte_s);
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // Datapath and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= 18'd0;
      left_q    <= 18'd0;
      word_q    <= 16'h0000;
      rd_pipe_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      left_q    <= left_d;
      word_q    <= word_d;
      rd_pipe_q <= rd_pipe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sram_address = addr_q;
  assign bus.sram_we_n    = 1'b1;
  assign bus.uart_tx      = tx_s;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// -----------------------------------------------------------------------------
// tb_uart_sram_tx_interface
// Directed bench for uart_sram_tx_interface with BAUD_DIVISOR = 4.
// Cycle numbering: the edge that samples start ends cycle 0; cycle k is the
// period after the k-th following edge. Outputs are sampled on negedges.
// -----------------------------------------------------------------------------
module tb_uart_sram_tx_interface;

  localparam int B = 4;
`ifdef TX_CHECKSUM_EN
  localparam int CK = 10 * B;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_sram_tx_interface_if ifc ();

  uart_sram_tx_interface #(
    .BAUD_DIVISOR (B)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // SRAM model: data for the address of cycle k appears in cycle k+2.
  logic [15:0] mem [0:255];
  logic [15:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[ifc.sram_address[7:0]];
    rd2 <= rd1;
  end
  assign ifc.sram_read_data = rd2;

  int checks   = 0;
  int failures = 0;

  logic        line_a [0:511];
  logic [17:0] addr_a [0:511];
  logic        busy_a [0:511];
  int          done_cyc;
  int          done_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected 10-bit frame: start bit in bit 0, stop bit in bit 9.
  function automatic logic [31:0] fr(input logic [7:0] b);
    return {22'd0, 1'b1, b, 1'b0};
  endfunction

  // Rebuild a frame from the captured line; a bit not stable for B cycles reads as x.
  function automatic logic [31:0] frame_at(input int first);
    logic [9:0] f;
    logic       v;
    for (int b = 0; b < 10; b++) begin
      v = line_a[first + b*B];
      for (int j = 1; j < B; j++) begin
        if (line_a[first + b*B + j] !== v) v = 1'bx;
      end
      f[b] = v;
    end
    return {22'd0, f};
  endfunction

  task automatic do_start(input logic [17:0] a, input logic [17:0] n);
    @(negedge clk);
    ifc.start_address = a;
    ifc.word_count    = n;
    ifc.start         = 1'b1;
  endtask

  // Record ncyc cycles after start; optionally re-pulse start while busy.
  task automatic run(input int ncyc, input int poke);
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      line_a[c] = ifc.uart_tx;
      addr_a[c] = ifc.sram_address;
      busy_a[c] = ifc.busy;
      if (ifc.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 1) ifc.start = 1'b0;
      if (c == poke) begin
        ifc.start         = 1'b1;
        ifc.start_address = 18'd5;
        ifc.word_count    = 18'd7;
      end
      if (c == poke + 1) ifc.start = 1'b0;
    end
  endtask

  initial begin
    int hi;
    ifc.start         = 1'b0;
    ifc.start_address = 18'd0;
    ifc.word_count    = 18'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]   = 16'hA55A;
    mem[100] = 16'h0102;
    mem[101] = 16'h0304;
    mem[102] = 16'h0506;
    mem[200] = 16'h3C81;
    mem[255] = 16'hBEEF;
    mem[44]  = 16'h1234;
    mem[45]  = 16'hFFFF;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(ifc.sram_address), 32'd0);
    check("rst_we_n", 32'(ifc.sram_we_n), 32'd1);
    check("rst_tx",   32'(ifc.uart_tx), 32'd1);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    rst = 1'b0;

    // 1: single word A55A at address 0
    do_start(18'd0, 18'd1);
    run(100 + CK, -1);
    check("t1_addr",     32'(addr_a[1]), 32'd0);
    check("t1_busy1",    32'(busy_a[1]), 32'd1);
    check("t1_pre_line", 32'(line_a[3]), 32'd1);
    check("t1_frame_hi", frame_at(4),  fr(8'hA5));
    check("t1_frame_lo", frame_at(44), fr(8'h5A));
    check("t1_done_cyc", 32'(done_cyc), 32'(84 + CK));
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy_end", 32'(busy_a[84 + CK]), 32'd1);
    check("t1_busy_off", 32'(busy_a[85 + CK]), 32'd0);
    check("t1_idle_tx",  32'(line_a[85 + CK]), 32'd1);

    // 2: three words back-to-back, start and inputs poked while busy
    do_start(18'd100, 18'd3);
    run(260 + CK, 50);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_frame%0d", k), frame_at(4 + 40*k), fr(8'(k + 1)));
    end
    check("t2_done_cyc", 32'(done_cyc), 32'(244 + CK));
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_addr_end", 32'(addr_a[240]), 32'd102);

    // 3: zero words
    do_start(18'd7, 18'd0);
    run(20 + CK, -1);
`ifdef TX_CHECKSUM_EN
    check("t3_frame_chk", frame_at(1), fr(8'h00));
    check("t3_done_cyc",  32'(done_cyc), 32'd41);
    check("t3_busy_off",  32'(busy_a[42]), 32'd0);
`else
    hi = 1;
    for (int c = 1; c <= 20; c++) if (line_a[c] !== 1'b1) hi = 0;
    check("t3_line_idle", 32'(hi), 32'd1);
    check("t3_done_cyc",  32'(done_cyc), 32'd1);
    check("t3_busy1",     32'(busy_a[1]), 32'd1);
    check("t3_busy_off",  32'(busy_a[2]), 32'd0);
`endif

    // 4: address wrap 3FFFF -> 0
    do_start(18'h3FFFF, 18'd2);
    run(180 + CK, -1);
    check("t4_addr_first", 32'(addr_a[1]),  32'h3FFFF);
    check("t4_addr_hold",  32'(addr_a[43]), 32'h3FFFF);
    check("t4_addr_wrap",  32'(addr_a[44]), 32'd0);
    check("t4_addr_last",  32'(addr_a[170]), 32'd0);
    check("t4_frame0", frame_at(4),   fr(8'hBE));
    check("t4_frame1", frame_at(44),  fr(8'hEF));
    check("t4_frame2", frame_at(84),  fr(8'hA5));
    check("t4_frame3", frame_at(124), fr(8'h5A));
    check("t4_done_cyc", 32'(done_cyc), 32'(164 + CK));

    // 5: reset during a data bit of the first word, then clean restart
    do_start(18'd100, 18'd3);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) ifc.start = 1'b0;
    end
    check("t5_line_low", 32'(ifc.uart_tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_tx",   32'(ifc.uart_tx), 32'd1);
    check("t5_rst_busy", 32'(ifc.busy), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_idle_tx", 32'(ifc.uart_tx), 32'd1);
    do_start(18'd200, 18'd1);
    run(100 + CK, -1);
    check("t5_addr",     32'(addr_a[1]), 32'd200);
    check("t5_frame_hi", frame_at(4),  fr(8'h3C));
    check("t5_frame_lo", frame_at(44), fr(8'h81));
    check("t5_done_cyc", 32'(done_cyc), 32'(84 + CK));

`ifdef TX_CHECKSUM_EN
    // 6: checksum of 12+34+FF+FF = 0x44
    do_start(18'd300, 18'd2);
    run(220, -1);
    check("t6_frame0",  frame_at(4),   fr(8'h12));
    check("t6_frame1",  frame_at(44),  fr(8'h34));
    check("t6_frame2",  frame_at(84),  fr(8'hFF));
    check("t6_frame3",  frame_at(124), fr(8'hFF));
    check("t6_chk",     frame_at(164), fr(8'h44));
    check("t6_done_cyc", 32'(done_cyc), 32'd204);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
